// File: rtl/dds_pkg.sv
// Shared types for the DDS step sequencer: form codes, step entry and FSM states.
// DDS_SEQ_SWEEP_EN adds a per-step phase-increment delta to the entry.
package dds_pkg;

    localparam int DDS_ACC_W = 32;
    localparam int DDS_DUR_W = 24;

    localparam logic [2:0] FORM_SAW       = 3'd0;
    localparam logic [2:0] FORM_RSAW      = 3'd1;
    localparam logic [2:0] FORM_TRI       = 3'd2;
    localparam logic [2:0] FORM_MEANDER   = 3'd3;
    localparam logic [2:0] FORM_MEANDER25 = 3'd4;

    typedef struct packed {
        logic [2:0]           form;
        logic [DDS_ACC_W-1:0] adder;
        logic [DDS_DUR_W-1:0] dur;
        logic                 last;
`ifdef DDS_SEQ_SWEEP_EN
        logic [DDS_ACC_W-1:0] delta;
`endif
    } step_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // A zero-length step still plays for one cycle.
    function automatic logic [DDS_DUR_W-1:0] eff_dur(input logic [DDS_DUR_W-1:0] dur);
        if (dur == {DDS_DUR_W{1'b0}}) begin
            eff_dur = {{(DDS_DUR_W-1){1'b0}}, 1'b1};
        end else begin
            eff_dur = dur;
        end
    endfunction

endpackage

// File: rtl/dds_seq_ctrl_if.sv
// Host/configuration and waveform-path signals of the DDS step sequencer.
// DDS_SEQ_SWEEP_EN adds cfg_delta.
interface dds_seq_ctrl_if #(
    parameter int STEPS = 8,
    parameter int DUR_W = 24,
    parameter int ACC_W = 32
);
    localparam int IDX_W = $clog2(STEPS);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [2:0]       cfg_form;
    logic [ACC_W-1:0] cfg_adder;
    logic [DUR_W-1:0] cfg_dur;
    logic             cfg_last;
`ifdef DDS_SEQ_SWEEP_EN
    logic [ACC_W-1:0] cfg_delta;
`endif
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [ACC_W-1:0] adder_out;
    logic [2:0]       form_out;
    logic             phase_clr;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] step_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_form, cfg_adder, cfg_dur, cfg_last,
`ifdef DDS_SEQ_SWEEP_EN
        output cfg_delta,
`endif
        output start, stop, loop_en,
        input  adder_out, form_out, phase_clr, busy, done, step_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_form, cfg_adder, cfg_dur, cfg_last,
`ifdef DDS_SEQ_SWEEP_EN
        input  cfg_delta,
`endif
        input  start, stop, loop_en,
        output adder_out, form_out, phase_clr, busy, done, step_idx
    );

endinterface

// File: rtl/dds_step_table.sv
// Step table register file: one write port, one combinational read port.
// Entry layout follows dds_pkg::step_t (DDS_SEQ_SWEEP_EN adds delta).
module dds_step_table
    import dds_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int IDX_W = $clog2(STEPS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  step_t            wr_entry,
    input  logic [IDX_W-1:0] rd_addr,
    output step_t            rd_entry
);

    step_t tbl_r [STEPS];

    // Entry storage, cleared by reset, written by the host at any time.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_r[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_r[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = tbl_r[rd_addr];

endmodule

// File: rtl/dds_seq_ctrl.sv
// DDS step sequencer: plays the host-written step table into the phase accumulator.
// DDS_SEQ_SWEEP_EN enables a per-cycle linear sweep of the phase increment within a step.
module dds_seq_ctrl
    import dds_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int DUR_W = DDS_DUR_W,
    parameter int ACC_W = DDS_ACC_W
) (
    input  logic           CLK,
    input  logic           RESET,
    dds_seq_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(STEPS);

    seq_state_e       state_r, state_nxt_s;
    logic [ACC_W-1:0] adder_r, adder_nxt_s;
    logic [2:0]       form_r, form_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [DUR_W-1:0] cnt_r, cnt_nxt_s;
    logic             last_r, last_nxt_s;
    logic             clr_r, clr_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
`ifdef DDS_SEQ_SWEEP_EN
    logic [ACC_W-1:0] delta_r, delta_nxt_s;
`endif

    step_t            wr_ent_s;
    step_t            ld_ent_s;
    logic [IDX_W-1:0] ld_idx_s;
    logic             seq_end_s;
    logic             load_s;

    // Pack the host write fields into a table entry.
    always_comb begin
        wr_ent_s       = '0;
        wr_ent_s.form  = bus.cfg_form;
        wr_ent_s.adder = bus.cfg_adder;
        wr_ent_s.dur   = bus.cfg_dur;
        wr_ent_s.last  = bus.cfg_last;
`ifdef DDS_SEQ_SWEEP_EN
        wr_ent_s.delta = bus.cfg_delta;
`endif
    end

    dds_step_table #(
        .STEPS (STEPS),
        .IDX_W (IDX_W)
    ) u_table (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_en    (bus.cfg_we),
        .wr_addr  (bus.cfg_addr),
        .wr_entry (wr_ent_s),
        .rd_addr  (ld_idx_s),
        .rd_entry (ld_ent_s)
    );

    // The last flag is the one latched at load, so host rewrites cannot cut a running step short.
    assign seq_end_s = last_r || (idx_r == IDX_W'(STEPS - 1));

    // Index of the entry that the next load would take.
    always_comb begin
        ld_idx_s = '0;
        if ((state_r == ST_RUN) && !seq_end_s) begin
            ld_idx_s = idx_r + IDX_W'(1);
        end else begin
            ld_idx_s = '0;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt_s = state_r;
        adder_nxt_s = adder_r;
        form_nxt_s  = form_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        clr_nxt_s   = 1'b0;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        load_s      = 1'b0;
`ifdef DDS_SEQ_SWEEP_EN
        delta_nxt_s = delta_r;
`endif
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s  = 1'b0;
                adder_nxt_s = '0;
                if (bus.start && !bus.stop) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                    adder_nxt_s = '0;
                    busy_nxt_s  = 1'b0;
                end else if (cnt_r == DUR_W'(1)) begin
                    if (seq_end_s && !bus.loop_en) begin
                        state_nxt_s = ST_IDLE;
                        adder_nxt_s = '0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - DUR_W'(1);
`ifdef DDS_SEQ_SWEEP_EN
                    adder_nxt_s = adder_r + delta_r;
`else
                    adder_nxt_s = adder_r;
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                adder_nxt_s = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase

        if (load_s) begin
            adder_nxt_s = ld_ent_s.adder;
            form_nxt_s  = ld_ent_s.form;
            idx_nxt_s   = ld_idx_s;
            cnt_nxt_s   = eff_dur(ld_ent_s.dur);
            last_nxt_s  = ld_ent_s.last;
            clr_nxt_s   = 1'b1;
            busy_nxt_s  = 1'b1;
`ifdef DDS_SEQ_SWEEP_EN
            delta_nxt_s = ld_ent_s.delta;
`endif
        end else begin
            clr_nxt_s = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            adder_r <= '0;
            form_r  <= FORM_SAW;
            idx_r   <= '0;
            cnt_r   <= '0;
            last_r  <= 1'b0;
            clr_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef DDS_SEQ_SWEEP_EN
            delta_r <= '0;
`endif
        end else begin
            state_r <= state_nxt_s;
            adder_r <= adder_nxt_s;
            form_r  <= form_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
            clr_r   <= clr_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
`ifdef DDS_SEQ_SWEEP_EN
            delta_r <= delta_nxt_s;
`endif
        end
    end

    assign bus.adder_out = adder_r;
    assign bus.form_out  = form_r;
    assign bus.step_idx  = idx_r;
    assign bus.phase_clr = clr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Self-checking bench for dds_seq_ctrl: table-driven scenarios with a per-cycle expectation queue.
// Exercises the sweep path when DDS_SEQ_SWEEP_EN is defined.
module tb_dds_seq_ctrl;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    dds_seq_ctrl_if #(.STEPS(8), .DUR_W(24), .ACC_W(32)) bus ();

    dds_seq_ctrl #(.STEPS(8), .DUR_W(24), .ACC_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  form;
        logic [31:0] adder;
        logic [31:0] delta;
        logic [23:0] dur;
        logic        last;
    } ent_t;

    typedef struct packed {
        logic [31:0] adder;
        logic [2:0]  form;
        logic        clr;
        logic        busy;
        logic        done;
        logic [2:0]  idx;
    } exp_t;

    exp_t       q[$];
    ent_t       mdl[8];
    ent_t       vec[4][8];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] last_form = 3'd0;
    logic [2:0] last_idx = 3'd0;

    function automatic ent_t mk(input logic [2:0] f, input logic [31:0] a,
                                input logic [23:0] d, input logic l);
        ent_t e;
        e.form = f; e.adder = a; e.delta = 32'd0; e.dur = d; e.last = l;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv, input int cyc);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    task automatic check_rec(input exp_t e, input int cyc);
        chk("adder_out", bus.adder_out, e.adder, cyc);
        chk("form_out", 32'(bus.form_out), 32'(e.form), cyc);
        chk("phase_clr", 32'(bus.phase_clr), 32'(e.clr), cyc);
        chk("busy", 32'(bus.busy), 32'(e.busy), cyc);
        chk("done", 32'(bus.done), 32'(e.done), cyc);
        chk("step_idx", 32'(bus.step_idx), 32'(e.idx), cyc);
    endtask

    task automatic write_entry(input int a, input ent_t e);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(a);
        bus.cfg_form  = e.form;
        bus.cfg_adder = e.adder;
        bus.cfg_dur   = e.dur;
        bus.cfg_last  = e.last;
`ifdef DDS_SEQ_SWEEP_EN
        bus.cfg_delta = e.delta;
`endif
        @(negedge CLK);
        bus.cfg_we = 1'b0;
        mdl[a] = e;
    endtask

    task automatic load_table(input int s);
        for (int i = 0; i < 8; i++) write_entry(i, vec[s][i]);
    endtask

    // Push expected cycles of entry i (n<0: whole step).
    task automatic push_step(input int i, input int n);
        int   d;
        exp_t e;
        d = (mdl[i].dur == 24'd0) ? 1 : int'(mdl[i].dur);
        if (n >= 0 && n < d) d = n;
        for (int k = 0; k < d; k++) begin
            e.adder = mdl[i].adder;
`ifdef DDS_SEQ_SWEEP_EN
            e.adder = mdl[i].adder + 32'(k) * mdl[i].delta;
`endif
            e.form = mdl[i].form;
            e.clr  = (k == 0);
            e.busy = 1'b1;
            e.done = 1'b0;
            e.idx  = 3'(i);
            q.push_back(e);
        end
        last_form = mdl[i].form;
        last_idx  = 3'(i);
    endtask

    task automatic push_seq();
        for (int i = 0; i < 8; i++) begin
            push_step(i, -1);
            if (mdl[i].last) break;
        end
    endtask

    task automatic push_idle(input logic dn);
        exp_t e;
        e.adder = 32'd0; e.form = last_form; e.clr = 1'b0;
        e.busy = 1'b0; e.done = dn; e.idx = last_idx;
        q.push_back(e);
    endtask

    task automatic push_end();
        push_idle(1'b1);
        push_idle(1'b0);
    endtask

    // Start, then compare one queued record per cycle; optional stop / loop drop / write / restart.
    task automatic run_seq(input int stop_at, input int drop_at, input int wr_at, input int rs_at);
        int   c;
        exp_t e;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        c = 0;
        while (q.size() > 0 && c < 500) begin
            e = q.pop_front();
            check_rec(e, c);
            bus.stop  = (c == stop_at);
            bus.start = (c == rs_at);
            if (c == drop_at) bus.loop_en = 1'b0;
            bus.cfg_we = (c == wr_at);
            if (c == wr_at) begin
                bus.cfg_addr = 3'd0; bus.cfg_form = 3'd5; bus.cfg_adder = 32'hDEADBEEF;
                bus.cfg_dur = 24'd7; bus.cfg_last = 1'b1;
            end
            @(negedge CLK);
            c++;
        end
        bus.stop = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0, c);
        q.delete();
    endtask

    initial begin
        exp_t z;
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_form = 3'd0; bus.cfg_adder = 32'd0;
        bus.cfg_dur = 24'd0; bus.cfg_last = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.loop_en = 1'b0;
`ifdef DDS_SEQ_SWEEP_EN
        bus.cfg_delta = 32'd0;
`endif
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        z = '0;

        for (int s = 0; s < 4; s++) for (int i = 0; i < 8; i++) vec[s][i] = '0;
        vec[0][0] = mk(3'd0, 32'h1000, 24'd3, 1'b0);
        vec[0][1] = mk(3'd2, 32'h2000, 24'd2, 1'b1);
        vec[1][0] = mk(3'd1, 32'h55, 24'd0, 1'b1);
        for (int i = 0; i < 8; i++) vec[2][i] = mk(3'(i % 5), 32'h111 * (i + 1), 24'(i % 3 + 1), 1'b0);
        vec[3][0] = mk(3'd4, 32'hA, 24'd1, 1'b0);
        vec[3][1] = mk(3'd3, 32'hB, 24'd1, 1'b0);
        vec[3][2] = mk(3'd2, 32'hC, 24'd1, 1'b1);
        vec[3][3] = mk(3'd1, 32'hD, 24'd5, 1'b0);

        repeat (2) @(negedge CLK);
        check_rec(z, -1);
        RESET = 1'b0;
        @(negedge CLK);

        // Table-driven sequences: basic (with rewrite + start while running), zero dur, full table, short.
        for (int s = 0; s < 4; s++) begin
            load_table(s);
            push_seq();
            push_end();
            if (s == 0) run_seq(-1, -1, 1, 2);
            else        run_seq(-1, -1, -1, -1);
        end

        // Loop: entry0 replays after entry1, loop_en dropped during the replay.
        load_table(0);
        bus.loop_en = 1'b1;
        push_seq();
        push_seq();
        push_end();
        run_seq(-1, 5, -1, -1);

        // Stop and start together while idle: stays idle.
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0; bus.stop = 1'b0;
        push_idle(1'b0);
        check_rec(q.pop_front(), 0);
        @(negedge CLK);
        push_idle(1'b0);
        check_rec(q.pop_front(), 1);

        // Stop in the first cycle of step 1: idle next cycle, no done.
        push_step(0, -1);
        push_step(1, 1);
        push_idle(1'b0);
        push_idle(1'b0);
        run_seq(3, -1, -1, -1);

        // Reset mid-run clears outputs immediately.
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1 check_rec(z, 100);
        @(negedge CLK);
        RESET = 1'b0;

        // Reset cleared the table: eight single-cycle zero steps, then done.
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        push_seq();
        push_end();
        run_seq(-1, -1, -1, -1);

`ifdef DDS_SEQ_SWEEP_EN
        begin
            ent_t e;
            e = mk(3'd0, 32'hFFFFFFFE, 24'd4, 1'b0);
            e.delta = 32'd1;
            write_entry(0, e);
            write_entry(1, mk(3'd1, 32'h10, 24'd1, 1'b1));
            push_seq();
            push_end();
            run_seq(-1, -1, -1, -1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_seq_ctrl.md
Name: dds_seq_ctrl

Overview:
- Step sequencer for the DDS waveform path.
- Holds a small host-written table of steps, each with a waveform form code, a phase increment and a duration in CLK cycles.
- Plays the steps in order and drives the form select and phase increment inputs of the phase accumulator and waveform former.
- Pulses a phase clear at each step boundary.

Parameters:
- STEPS, 8, number of table entries (power of two, >=2).
- DUR_W, 24, width of the per-step duration counter.
- ACC_W, 32, phase increment width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(STEPS)  table write index
- cfg_form  in  3  form code for the entry
- cfg_adder  in  ACC_W  phase increment for the entry
- cfg_dur  in  DUR_W  step length in CLK cycles; 0 treated as 1
- cfg_last  in  1  entry terminates the sequence
- start  in  1  begin sequence at entry 0
- stop  in  1  abort sequence
- loop_en  in  1  restart at entry 0 after the last step instead of finishing
- adder_out  out  ACC_W  phase increment to the accumulator
- form_out  out  3  form select to the waveform former
- phase_clr  out  1  one-cycle accumulator clear at every step load
- busy  out  1  sequence active
- done  out  1  one-cycle pulse on natural completion
- step_idx  out  $clog2(STEPS)  index of the step currently driven

Behaviour:
- Reset (async, RESET=1):
  - State IDLE.
  - adder_out=0, form_out=0, phase_clr=0, busy=0, done=0, step_idx=0.
  - All table entries cleared: form 0, adder 0, dur 0, last 0.
  - Reset mid-sequence aborts immediately; no done pulse.
- Table write: on any edge with cfg_we=1, entry[cfg_addr] takes the cfg_* values. Writes are allowed while busy. A step's values are sampled only when that step is loaded, so rewriting the active entry does not change the current outputs.
- States: IDLE, RUN.
- IDLE:
  - busy=0; adder_out=0; form_out holds its last value.
  - start=1 and stop=0 at edge k: after edge k, state=RUN, entry 0 is loaded, busy=1, phase_clr=1 for one cycle.
  - Start latency is one edge.
- Load action:
  - adder_out<=entry.adder; form_out<=entry.form; step_idx<=index.
  - cnt<=max(entry.dur,1); phase_clr<=1 for one cycle.
- RUN, each edge:
  - If cnt>1: cnt decrements.
  - If cnt==1, the step ends:
    - If entry.last=1 or step_idx==STEPS-1, and loop_en=1: load entry 0.
    - If entry.last=1 or step_idx==STEPS-1, and loop_en=0: go to IDLE, adder_out<=0, busy<=0, done<=1 for one cycle.
    - Otherwise: load step_idx+1.
- Step timing: each step drives its outputs for exactly max(dur,1) cycles, with no gap between steps.
- loop_en is sampled only at the end of the last step.
- stop=1 at any edge while RUN: next state IDLE, adder_out=0, busy=0, no done, no phase_clr. stop beats start and beats a same-edge step end.
- start while RUN is ignored.
- phase_clr and done are never asserted in the same cycle.

Optional Feature:
- DDS_SEQ_SWEEP_EN defined:
  - Adds input cfg_delta (ACC_W, two's complement) stored per entry.
  - On each RUN edge that does not load a new step, adder_out<=adder_out+delta, wrapping modulo 2^ACC_W with no saturation.
  - A load always restores entry.adder.
  - delta is cleared to 0 by reset.
- DDS_SEQ_SWEEP_EN not defined: no cfg_delta port; adder_out is constant within a step.

Decomposition:
- Shared package dds_pkg:
  - Form codes FORM_SAW=3'd0, FORM_RSAW=3'd1, FORM_TRI=3'd2, FORM_MEANDER=3'd3, FORM_MEANDER25=3'd4.
  - Step entry struct (form, adder, dur, last, optional delta).
  - Sequencer state enum.
- One sub-module, dds_step_table:
  - STEPS-entry register file with async reset.
  - Single write port, combinational read at step_idx / next index.

Test Plan:
- Basic sequence: entry0={form 0, adder 0x1000, dur 3}, entry1={form 2, adder 0x2000, dur 2, last}; start at edge 0.
  - adder_out=0x1000 for 3 cycles, then 0x2000 for 2 cycles, then 0.
  - phase_clr high in the first cycle of each step; done pulses once; busy high for 5 cycles.
- Loop: same table with loop_en=1.
  - After entry1 ends, entry0 reloads with phase_clr; no done.
  - Drop loop_en during entry0; the sequence finishes after entry1 with done.
- Zero duration: entry0 dur=0, last=1.
  - Step lasts exactly 1 cycle, then done.
- Full table: all STEPS entries with last=0.
  - step_idx runs 0..7, then the sequence finishes (loop_en=0).
- Stop: stop asserted mid-step 1, also test stop and start together in IDLE.
  - Mid-step: IDLE next cycle, adder_out=0, no done.
  - Together: stays IDLE.
  - RESET mid-RUN clears all outputs immediately.
- Sweep (DDS_SEQ_SWEEP_EN): entry0={adder 0xFFFFFFFE, delta +1, dur 4}.
  - adder_out=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001, then the next load.
